// File: rtl/chan_pack_pkg.sv
// Shared constants and helpers for the channel packer/arbiter.
// Arbitration mode encodings and the channel-id width rule live here.
package chan_pack_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  // A single channel still needs one id bit in the packet.
  function automatic int f_idw(input int nch);
    return (nch <= 1) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/chan_slot.sv
// One-entry holding slot for a single input channel.
// A push wins over a pop in the same cycle, so the slot stays full and takes new data.
module chan_slot #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         full
);

  logic [W-1:0] data_reg;
  logic         full_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      full_reg <= 1'b0;
      data_reg <= '0;
    end else if (push) begin
      full_reg <= 1'b1;
      data_reg <= d;
    end else if (pop) begin
      full_reg <= 1'b0;
    end
  end

  assign q    = data_reg;
  assign full = full_reg;

endmodule

// File: rtl/chan_pack_arb.sv
// NCH-channel packer: per-channel slots, a round-robin or fixed-priority arbiter,
// and a registered output packet {chan_id, data, parity}.
module chan_pack_arb
  import chan_pack_pkg::*;
#(
  parameter int  NCH        = 4,
  parameter int  W          = 5,
  parameter int  MODE       = 0,
  parameter int  PARITY_ODD = 0,
  localparam int IDW        = f_idw(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [NCH*W-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDW+W-1:-1]    out_pkt
);

  logic [NCH-1:0]        full;
  logic [NCH-1:0]        push;
  logic [NCH-1:0]        pop;
  logic [NCH-1:0][W-1:0] slot_q;
  logic [IDW-1:0]        ptr_reg;
  logic [IDW-1:0]        grant_idx;
  logic [IDW-1:0]        chan_id;
  logic [W-1:0]          grant_data;
  logic                  grant_found;
  logic                  advance;
  logic                  out_valid_reg;
  logic [IDW+W-1:-1]     out_pkt_reg;

  assign advance  = !out_valid_reg || out_ready;
  assign in_ready = rst ? '0 : (~full | pop);
  assign push     = in_valid & in_ready;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_slot
      chan_slot #(.W(W)) u_slot (
        .clk  (clk),
        .rst  (rst),
        .push (push[gi]),
        .pop  (pop[gi]),
        .d    (in_data[gi*W +: W]),
        .q    (slot_q[gi]),
        .full (full[gi])
      );
    end
  endgenerate

  // Scan order is reversed so the last hit is the highest-priority candidate.
  always_comb begin
    logic [IDW-1:0] sel;
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_data  = '0;
    sel         = '0;
    if (MODE == MODE_FIXED) begin
      for (int k = NCH - 1; k >= 0; k--) begin
        if (full[k]) begin
          grant_found = 1'b1;
          grant_idx   = IDW'(k);
          grant_data  = slot_q[k];
        end
      end
    end else begin
      for (int k = NCH; k >= 1; k--) begin
        sel = IDW'((int'(ptr_reg) + k) % NCH);
        if (full[sel]) begin
          grant_found = 1'b1;
          grant_idx   = sel;
          grant_data  = slot_q[sel];
        end
      end
    end
  end

  always_comb begin
    pop = '0;
    if (grant_found && advance && !rst) begin
      pop[grant_idx] = 1'b1;
    end
  end

  generate
    if (NCH == 1) begin : g_id_tie
      assign chan_id = 1'b0;
    end else begin : g_id_grant
      assign chan_id = grant_idx;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_pkt_reg   <= '0;
      ptr_reg       <= IDW'(NCH - 1);
    end else if (advance) begin
      if (grant_found) begin
        out_valid_reg <= 1'b1;
        out_pkt_reg   <= {chan_id, grant_data, (^{chan_id, grant_data}) ^ 1'(PARITY_ODD)};
        if (MODE == MODE_RR) begin
          ptr_reg <= grant_idx;
        end
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_pkt   = out_pkt_reg;

endmodule

// File: tb/tb_chan_pack_arb.sv
// Directed bench for chan_pack_arb: round-robin/even, round-robin/odd and fixed-priority
// instances, with expected packets queued at stimulus time and popped on each output transfer.
module tb_chan_pack_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [19:0] in_data;
  logic        out_ready;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [6:-1] out_pkt;
  logic [3:0]  po_in_ready;
  logic        po_valid;
  logic [6:-1] po_pkt;
  logic [3:0]  fp_valid;
  logic [19:0] fp_data;
  logic        fp_ready;
  logic [3:0]  fp_in_ready;
  logic        fp_out_valid;
  logic [6:-1] fp_pkt;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] fp_q[$];

  localparam logic [4:0] CHD [4] = '{5'h01, 5'h0A, 5'h13, 5'h1C};

  always #5 clk = ~clk;

  chan_pack_arb #(.NCH(4), .W(5), .MODE(0), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pkt(out_pkt));

  chan_pack_arb #(.NCH(4), .W(5), .MODE(0), .PARITY_ODD(1)) dut_po (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(po_in_ready), .in_data(in_data),
    .out_valid(po_valid), .out_ready(out_ready), .out_pkt(po_pkt));

  chan_pack_arb #(.NCH(4), .W(5), .MODE(1), .PARITY_ODD(0)) dut_fp (
    .clk(clk), .rst(rst), .in_valid(fp_valid), .in_ready(fp_in_ready), .in_data(fp_data),
    .out_valid(fp_out_valid), .out_ready(fp_ready), .out_pkt(fp_pkt));

  function automatic logic [7:0] mk(input int c, input bit odd);
    logic [1:0] id;
    logic [4:0] d;
    id = c[1:0];
    d  = CHD[c];
    return {id, d, (^{id, d}) ^ odd};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Compare transfers that will happen at the coming edge, then step past it.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    check("po_valid", 32'(po_valid), 32'(out_valid));
    check("po_in_ready", 32'(po_in_ready), 32'(in_ready));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("main_extra_pkt", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        check("main_pkt", 32'(out_pkt), 32'(e));
        check("po_pkt", 32'(po_pkt), 32'(e ^ 8'h01));
        $display("main xfer pkt=%h exp=%h", out_pkt, e);
      end
    end
    if (fp_out_valid && fp_ready) begin
      if (fp_q.size() == 0) check("fp_extra_pkt", fp_q.size(), 1);
      else begin
        e = fp_q.pop_front();
        check("fp_pkt", 32'(fp_pkt), 32'(e));
        $display("fp   xfer pkt=%h exp=%h", fp_pkt, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with all channels requesting.
    rst = 1'b1; in_valid = 4'hF; in_data = {CHD[3], CHD[2], CHD[1], CHD[0]}; out_ready = 1'b1;
    fp_valid = 4'h0; fp_data = {CHD[3], CHD[2], CHD[1], CHD[0]}; fp_ready = 1'b1;
    tick(); tick();
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_out_pkt", 32'(out_pkt), 0);
    check("reset_in_ready", 32'(in_ready), 0);

    // Round-robin fairness: 0,1,2,3,0 at one per cycle.
    exp_q.push_back(mk(0, 0)); exp_q.push_back(mk(1, 0)); exp_q.push_back(mk(2, 0));
    exp_q.push_back(mk(3, 0)); exp_q.push_back(mk(0, 0));
    rst = 1'b0;
    tick();
    check("fill_out_valid", 32'(out_valid), 0);
    tick();
    check("first_grant_pkt", 32'(out_pkt), 32'(mk(0, 0)));
    for (int i = 0; i < 5; i++) begin
      check("rr_valid", 32'(out_valid), 1);
      tick();
    end
    check("rr_drained", exp_q.size(), 0);

    // Backpressure: all slots full, output held.
    out_ready = 1'b0; in_valid = 4'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 32'(out_valid), 1);
      check("bp_pkt", 32'(out_pkt), 32'(mk(1, 0)));
      check("bp_in_ready", 32'(in_ready), 0);
    end
    exp_q.push_back(mk(1, 0)); exp_q.push_back(mk(2, 0)); exp_q.push_back(mk(3, 0));
    exp_q.push_back(mk(0, 0)); exp_q.push_back(mk(1, 0));
    out_ready = 1'b1;
    for (int i = 0; i < 12 && exp_q.size() > 0; i++) tick();
    check("bp_drained", exp_q.size(), 0);
    tick(); tick();
    check("bp_idle_valid", 32'(out_valid), 0);

    // Parity: ch2 data 5'h13 -> {2'd2, 5'h13, 0}.
    exp_q.push_back(8'hA6);
    in_valid = 4'b0100;
    tick();
    in_valid = 4'h0;
    for (int i = 0; i < 6 && exp_q.size() > 0; i++) tick();
    check("parity_drained", exp_q.size(), 0);

    // Fixed priority: ch1 starves ch3 until it drops.
    for (int i = 0; i < 6; i++) fp_q.push_back(mk(1, 0));
    for (int i = 0; i < 5; i++) fp_q.push_back(mk(3, 0));
    fp_valid = 4'b1010;
    for (int i = 0; i < 6; i++) tick();
    check("fp_ch1_only", fp_q.size(), 7);
    fp_valid = 4'b1000;
    for (int i = 0; i < 5; i++) tick();
    fp_valid = 4'b0000;
    for (int i = 0; i < 4; i++) tick();
    check("fp_drained", fp_q.size(), 0);
    check("fp_idle_ready", 32'(fp_in_ready), 32'hF);

    // Mid-stream reset with three slots full and a packet pending.
    out_ready = 1'b0; in_valid = 4'b0111;
    tick(); tick();
    check("mid_pre_valid", 32'(out_valid), 1);
    rst = 1'b1; in_valid = 4'h0;
    tick();
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_pkt", 32'(out_pkt), 0);
    check("mid_rst_in_ready", 32'(in_ready), 0);
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("mid_post_valid", 32'(out_valid), 0);
    check("mid_post_in_ready", 32'(in_ready), 32'hF);
    check("final_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
